xil_bram_sdp_1clk_depth_clr: RTL and testbench

XIL_BRAM_SDP_1CLK_DEPTH_CLR -- requirements
Module: xil_bram_sdp_1clk_depth_clr

---
 rtl/xil_bram_depth_pkg.sv | 19 +
 rtl/xil_bram_sdp_1clk.sv | 39 +++
 rtl/xil_bram_sdp_1clk_depth_clr.sv | 150 +++++++++++++++
 tb/tb_xil_bram_sdp_1clk_depth_clr.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/xil_bram_depth_pkg.sv
// Shared definitions for the banked, zero-filled simple-dual-port RAM.
package xil_bram_depth_pkg;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_e;

  // Number of 2^bnk_adr-word banks needed to hold dep words.
  function automatic int nbank_f(input int dep, input int bnk_adr);
    return (dep + (1 << bnk_adr) - 1) >> bnk_adr;
  endfunction

  // Width of a bank index; never below one bit so vectors stay legal.
  function automatic int bidx_w_f(input int nbank);
    return (nbank <= 1) ? 1 : $clog2(nbank);
  endfunction

endpackage

// File: rtl/xil_bram_sdp_1clk.sv
// One bank: single-clock simple-dual-port RAM, read-first, DEL-cycle read latency.
module xil_bram_sdp_1clk #(
  parameter int ADR = 10,
  parameter int DAT = 18,
  parameter int DEL = 2
) (
  input  logic           clk_i,
  input  logic           wen_i,
  input  logic [ADR-1:0] wad_i,
  input  logic [DAT-1:0] wda_i,
  input  logic           ren_i,
  input  logic [ADR-1:0] rad_i,
  output logic [DAT-1:0] rda_o
);

  logic [DAT-1:0] mem_q [2**ADR];
  logic [DAT-1:0] ram_q;

  // RAM array: read and write in one process so a same-address access returns the old word
  always_ff @(posedge clk_i) begin
    if (ren_i) ram_q <= mem_q[rad_i];
    if (wen_i) mem_q[wad_i] <= wda_i;
  end

  if (DEL == 1) begin : g_d1
    assign rda_o = ram_q;
  end else begin : g_dn
    logic [DEL-2:0][DAT-1:0] out_q;

    // Free-running output registers; the top picks the right stage via its own valid pipe
    always_ff @(posedge clk_i) begin
      out_q[0] <= ram_q;
      for (int j = 1; j < DEL - 1; j++) out_q[j] <= out_q[j-1];
    end

    assign rda_o = out_q[DEL-2];
  end

endmodule

// File: rtl/xil_bram_sdp_1clk_depth_clr.sv
// Arbitrary-depth RAM built from 2^BNK_ADR-word banks, zero-filled after reset,
// with range checking and a latency-matched output mux.
module xil_bram_sdp_1clk_depth_clr
  import xil_bram_depth_pkg::*;
#(
  parameter int ADR     = 12,
  parameter int DAT     = 18,
  parameter int DEP     = 3000,
  parameter int BNK_ADR = 10,
  parameter int DEL     = 2,
  parameter int CLR_EN  = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           wen,
  input  logic [ADR-1:0] wad,
  input  logic [DAT-1:0] wda,
  input  logic           ren,
  input  logic [ADR-1:0] rad,
  output logic [DAT-1:0] rda,
  output logic           rvld,
  output logic           init_done,
  output logic           oor_err
);

  localparam int             NBANK = nbank_f(DEP, BNK_ADR);
  localparam int             BIW   = bidx_w_f(NBANK);
  localparam logic [ADR:0]   DEP_L = (ADR+1)'(DEP);
  localparam logic [ADR-1:0] LAST  = ADR'(DEP - 1);

  state_e         state_q, state_d;
  logic [ADR-1:0] clr_cnt_q, clr_cnt_d;

  // Reset parks the FSM in CLEAR; the fill (if enabled) starts on the first cycle after release
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Next state: CLEAR walks the counter over 0..DEP-1, then READY forever
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      S_CLEAR: begin
        if (CLR_EN == 0) begin
          state_d = S_READY;
        end else if (clr_cnt_q == LAST) begin
          state_d   = S_READY;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  logic           acc_en, fill, w_in, r_in, wr_en, rd_en;
  logic [ADR-1:0] wr_adr;
  logic [DAT-1:0] wr_dat;
  logic [BIW-1:0] wbank, rbank;

  // rst gates every RAM write so contents only change through the fill
  assign acc_en = (state_q == S_READY) && !rst;
  assign fill   = (state_q == S_CLEAR) && !rst && (CLR_EN != 0);
  assign w_in   = {1'b0, wad} < DEP_L;
  assign r_in   = {1'b0, rad} < DEP_L;
  assign wr_en  = fill || (acc_en && wen && w_in);
  assign rd_en  = acc_en && ren;
  assign wr_adr = fill ? clr_cnt_q : wad;
  assign wr_dat = fill ? '0 : wda;
  assign wbank  = BIW'(wr_adr >> BNK_ADR);
  assign rbank  = BIW'(rad >> BNK_ADR);

  logic [NBANK-1:0][DAT-1:0] bank_rda;

  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    xil_bram_sdp_1clk #(
      .ADR(BNK_ADR),
      .DAT(DAT),
      .DEL(DEL)
    ) u_bank (
      .clk_i(clk),
      .wen_i(wr_en && (wbank == BIW'(b))),
      .wad_i(wr_adr[BNK_ADR-1:0]),
      .wda_i(wr_dat),
      .ren_i(rd_en && r_in && (rbank == BIW'(b))),
      .rad_i(rad[BNK_ADR-1:0]),
      .rda_o(bank_rda[b])
    );
  end

  logic [DEL-1:0]          vld_q, inr_q;
  logic [DEL-1:0][BIW-1:0] bnk_q;

  // Valid pipe: flushed on reset so in-flight reads vanish
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= rd_en;
      for (int j = 1; j < DEL; j++) vld_q[j] <= vld_q[j-1];
    end
  end

  // Bank select and range flag travel alongside the RAM data
  always_ff @(posedge clk) begin
    inr_q[0] <= r_in;
    bnk_q[0] <= rbank;
    for (int j = 1; j < DEL; j++) begin
      inr_q[j] <= inr_q[j-1];
      bnk_q[j] <= bnk_q[j-1];
    end
  end

  logic [DAT-1:0] rd_mux, rda_q;

  // Output mux: out-of-range reads return zero
  always_comb begin
    rd_mux = '0;
    for (int b = 0; b < NBANK; b++)
      if (inr_q[DEL-1] && (bnk_q[DEL-1] == BIW'(b))) rd_mux = bank_rda[b];
  end

  // Hold the last delivered word while no read is completing
  always_ff @(posedge clk) begin
    if (rst)               rda_q <= '0;
    else if (vld_q[DEL-1]) rda_q <= rd_mux;
  end

  logic oor_q;

  // One pulse per cycle however many ports were out of range
  always_ff @(posedge clk) begin
    if (rst) oor_q <= 1'b0;
    else     oor_q <= acc_en && ((wen && !w_in) || (ren && !r_in));
  end

  assign rvld      = vld_q[DEL-1];
  assign rda       = vld_q[DEL-1] ? rd_mux : rda_q;
  assign init_done = (state_q == S_READY);
  assign oor_err   = oor_q;

endmodule

// File: tb/tb_xil_bram_sdp_1clk_depth_clr.sv
// Directed bench: four instances (DEL=2, DEL=1, DEL=3, CLR_EN=0) share one stimulus stream.
module tb_xil_bram_sdp_1clk_depth_clr;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wen = 1'b0, ren = 1'b0, un_en = 1'b0;
  logic [11:0] wad = '0, rad = '0;
  logic [17:0] wda = '0;

  logic [17:0] rda0, rda1, rda3, rdan;
  logic        rv0, rv1, rv3, rvn;
  logic        id0, id1, id3, idn;
  logic        oo0, oo1, oo3, oon;

  int checks = 0;
  int errors = 0;

  logic [11:0] ra [8];
  logic [17:0] re [8];
  logic [17:0] last0 = '0, last1 = '0, last3 = '0, lastn = '0;

  always #5 clk = ~clk;

  xil_bram_sdp_1clk_depth_clr u0 (
    .clk(clk), .rst(rst), .wen(wen), .wad(wad), .wda(wda), .ren(ren), .rad(rad),
    .rda(rda0), .rvld(rv0), .init_done(id0), .oor_err(oo0));

  xil_bram_sdp_1clk_depth_clr #(.DEL(1)) u1 (
    .clk(clk), .rst(rst), .wen(wen), .wad(wad), .wda(wda), .ren(ren), .rad(rad),
    .rda(rda1), .rvld(rv1), .init_done(id1), .oor_err(oo1));

  xil_bram_sdp_1clk_depth_clr #(.DEL(3)) u3 (
    .clk(clk), .rst(rst), .wen(wen), .wad(wad), .wda(wda), .ren(ren), .rad(rad),
    .rda(rda3), .rvld(rv3), .init_done(id3), .oor_err(oo3));

  xil_bram_sdp_1clk_depth_clr #(.CLR_EN(0)) un (
    .clk(clk), .rst(rst), .wen(wen), .wad(wad), .wda(wda), .ren(ren && un_en), .rad(rad),
    .rda(rdan), .rvld(rvn), .init_done(idn), .oor_err(oon));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [11:0] a, input logic [17:0] d);
    wen = 1'b1; wad = a; wda = d;
    step();
    wen = 1'b0;
  endtask

  // Checks one instance after step t of a burst of n reads issued on cycles 1..n
  task automatic chk_rd(input string tag, input logic rv, input logic [17:0] rd,
                        input int d, input int t, input int n, inout logic [17:0] last);
    int   i;
    logic ev;
    logic [17:0] ed;
    i  = t - d;
    ev = (i >= 0) && (i < n);
    ed = ev ? re[i] : last;
    chk({tag, " rvld"}, {31'd0, rv}, {31'd0, ev});
    chk({tag, " rda"}, {14'd0, rd}, {14'd0, ed});
    if (ev) last = ed;
  endtask

  // Back-to-back reads from ra[0..n-1]; any wen set by the caller lasts one cycle
  task automatic do_reads(input int n, input bit inc_un, input bit exp_oor);
    for (int t = 1; t <= n + 3; t++) begin
      if (t <= n) begin
        ren = 1'b1; rad = ra[t-1]; un_en = inc_un;
      end else begin
        ren = 1'b0; un_en = 1'b0;
      end
      step();
      if (t == 1) begin
        wen = 1'b0;
        chk("oor_err pulse", {31'd0, oo0}, {31'd0, exp_oor});
      end
      if (t == 2 && exp_oor) chk("oor_err single", {31'd0, oo0}, 32'd0);
      chk_rd("d2", rv0, rda0, 2, t, n, last0);
      chk_rd("d1", rv1, rda1, 1, t, n, last1);
      chk_rd("d3", rv3, rda3, 3, t, n, last3);
      if (inc_un) chk_rd("noclr", rvn, rdan, 2, t, n, lastn);
    end
  endtask

  initial begin
    int  n;
    bit  any_rv;

    // Reset state
    step(); step();
    chk("rst rda", {14'd0, rda0}, 32'd0);
    chk("rst rvld", {31'd0, rv0}, 32'd0);
    chk("rst oor_err", {31'd0, oo0}, 32'd0);
    chk("rst init_done", {31'd0, id0}, 32'd0);
    chk("rst init_done noclr", {31'd0, idn}, 32'd0);

    // Release with wen/ren held: CLEAR must ignore both
    ren = 1'b1; rad = 12'd5; wen = 1'b1; wad = 12'd5; wda = 18'h3FFFF;
    rst = 1'b0;
    any_rv = 1'b0;
    step();
    chk("noclr init 1 cycle", {31'd0, idn}, 32'd1);
    chk("clr init not yet", {31'd0, id0}, 32'd0);
    for (int k = 1; k < 1500; k++) begin
      step();
      if (rv0 || rv1 || rv3) any_rv = 1'b1;
    end

    // Reset mid-fill restarts at address 0
    rst = 1'b1;
    step();
    rst = 1'b0;
    n = 0;
    while (!id0 && n < 4000) begin
      step();
      n++;
      if (rv0 || rv1 || rv3 || oo0) any_rv = 1'b1;
    end
    ren = 1'b0; wen = 1'b0;
    chk("clear length", n, 32'd3000);
    chk("rvld in clear", {31'd0, any_rv}, 32'd0);
    chk("init_done d1", {31'd0, id1}, 32'd1);
    chk("init_done d3", {31'd0, id3}, 32'd1);
    chk("init_done noclr", {31'd0, idn}, 32'd1);

    // Last word and a word written-at during CLEAR both read zero
    ra[0] = 12'd2999; re[0] = 18'h00000;
    ra[1] = 12'd5;    re[1] = 18'h00000;
    do_reads(2, 1'b0, 1'b0);

    // Bank boundary 1023/1024
    wr(12'd1023, 18'h15A5A);
    wr(12'd1024, 18'h0F0F0);
    ra[0] = 12'd1024; re[0] = 18'h0F0F0;
    ra[1] = 12'd1023; re[1] = 18'h15A5A;
    do_reads(2, 1'b1, 1'b0);

    // Out-of-range write: pulse, nothing written into bank 2 or its aliases
    wr(12'd3000, 18'h3FFFF);
    chk("oor wr pulse", {31'd0, oo0}, 32'd1);
    step();
    chk("oor wr drop", {31'd0, oo0}, 32'd0);
    ra[0] = 12'd2999; re[0] = 18'h0;
    ra[1] = 12'd1976; re[1] = 18'h0;
    ra[2] = 12'd952;  re[2] = 18'h0;
    do_reads(3, 1'b0, 1'b0);

    // Out-of-range read plus simultaneous out-of-range write: one pulse, rda=0
    wen = 1'b1; wad = 12'd3001; wda = 18'h00001;
    ra[0] = 12'd4095; re[0] = 18'h0;
    do_reads(1, 1'b1, 1'b1);

    // Read-first collision at address 5
    wr(12'd5, 18'h00011);
    wen = 1'b1; wad = 12'd5; wda = 18'h00022;
    ra[0] = 12'd5; re[0] = 18'h00011;
    do_reads(1, 1'b1, 1'b0);
    ra[0] = 12'd5; re[0] = 18'h00022;
    do_reads(1, 1'b1, 1'b0);

    // Streaming across three banks
    wr(12'd10,   18'h12345);
    wr(12'd1030, 18'h2ABCD);
    wr(12'd2050, 18'h3C0DE);
    ra[0] = 12'd10;   re[0] = 18'h12345;
    ra[1] = 12'd1030; re[1] = 18'h2ABCD;
    ra[2] = 12'd2050; re[2] = 18'h3C0DE;
    ra[3] = 12'd10;   re[3] = 18'h12345;
    do_reads(4, 1'b1, 1'b0);

    // Reset during a read burst discards the in-flight reads
    ren = 1'b1; rad = 12'd10;
    step();
    ren = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    any_rv = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (rv0 || rv1 || rv3) any_rv = 1'b1;
    end
    chk("rvld after rst", {31'd0, any_rv}, 32'd0);
    chk("rda after rst", {14'd0, rda0}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
